cb_bitop_seq: RTL
=================

Name: cb_bitop_seq

Overview:
- Multi-cycle sequencer for CB-prefixed BIT/RES/SET instructions (opcodes CB 40-FF) in the GB CPU core.
- Sits directly upstream of the bit ALU. Latches the opcode from the decoder, fetches the operand from the register file or from (HL), drives the ALU, and writes back the result or flags on M-cycle boundaries.
- CB 00-3F (rotates/shifts/SWAP) are not executed here; they are flagged as an error back to the decoder.

Parameters:
- None. The core is fixed 8-bit with a 16-bit address.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous reset, active-high
- mcyc_en  in  1  one-clk strobe marking the last T-cycle of each M-cycle
- start  in  1  opcode valid, sampled in IDLE on any clk
- opcode  in  8  second byte of the CB instruction
- busy  out  1  high from the clk after start is accepted until done
- done  out  1  one-clk pulse at instruction completion
- err  out  1  one-clk pulse, coincident with done, for opcode[7:6]==00
- reg_sel  out  3  register index (opcode[2:0]); B,C,D,E,H,L,-,A
- reg_rdata  in  8  combinational read of reg_sel
- reg_we  out  1  one-clk register write strobe
- reg_wdata  out  8  register write data
- hl  in  16  current HL
- mem_addr  out  16  bus address; equals the latched HL in memory states
- mem_rd  out  1  read request, held for a whole M-cycle
- mem_rdata  in  8  read data, valid at mcyc_en
- mem_wr  out  1  write request, held for a whole M-cycle
- mem_wdata  out  8  write data
- f_in  in  8  current F register
- f_we  out  1  one-clk flag write strobe
- f_out  out  8  new F value

Behaviour:
- Reset values: all outputs 0; state=IDLE; latched opcode, HL and tmp registers = 0.
- Field decode:
  - grp = op[7:6]: 01=BIT, 10=RES, 11=SET.
  - b = op[5:3].
  - r = op[2:0]; r==6 selects the (HL) operand.
- States: IDLE, EXEC_R, MEM_RD, MEM_WR, ERR.
- IDLE:
  - When start is high: latch opcode and hl.
  - If grp==00, go to ERR; else if r!=6, go to EXEC_R; else go to MEM_RD.
  - busy rises on the next clk.
- ERR: on the next clk, pulse done and err, then return to IDLE. No write or flag strobes are issued. mcyc_en is not required.
- EXEC_R: wait for mcyc_en. In that clk:
  - BIT: f_we=1 and f_out = {~a[b],0,1,f_in[4],4'b0000}.
  - RES/SET: reg_we=1 and reg_wdata = a with bit b cleared or set.
  - Pulse done and go to IDLE.
  - Latency is 1 M-cycle after start.
- MEM_RD:
  - mem_rd=1 and mem_addr = latched HL for the whole M-cycle.
  - At mcyc_en, capture tmp = mem_rdata.
  - BIT: issue f_we with the same f_out formula, pulse done, go to IDLE.
  - RES/SET: go to MEM_WR.
- MEM_WR:
  - mem_wr=1, mem_addr = latched HL, mem_wdata = tmp with bit b cleared or set, held for the whole M-cycle.
  - At mcyc_en, pulse done and go to IDLE.
  - Total latency is 2 M-cycles.
- Flags: only Z/N/H change. C is passed through from f_in. F[3:0] is always written as 0. RES/SET never assert f_we.
- Exclusivity: reg_we, f_we and mem_wr are mutually exclusive.
- start while busy is ignored. HL changing mid-instruction does not affect mem_addr, because it is latched.
- reset mid-operation: next clk is IDLE with all strobes low. Any pending write is dropped.
- mcyc_en arriving in the same clk as start is not consumed; the first M-cycle begins after acceptance.
- done and the final write strobe are high in the same clk.

Decomposition:
- Shared package cb_pkg holds:
  - state enum: IDLE, EXEC_R, MEM_RD, MEM_WR, ERR
  - group constants: GRP_ROT=2'b00, GRP_BIT=2'b01, GRP_RES=2'b10, GRP_SET=2'b11
  - R_HL_IND=3'd6
  - flag bit positions: FZ=7, FN=6, FH=5, FC=4
- Sub-module: instantiate the existing bitalu as the datapath.
  - Operand is a = reg_rdata or tmp; b is taken from the opcode.
  - Control is mapped from grp.
  - C is merged from f_in in this block.

Test Plan:
- BIT 7,H (op 7C), reg_rdata=0x80, f_in=0x10 -> after 1 M-cycle: f_we=1, f_out=0x30, done; no reg_we.
- SET 3,A (op DF), reg_rdata=0x00 -> reg_we=1, reg_sel=7, reg_wdata=0x08 in the mcyc_en clk; f_we stays 0.
- RES 0,(HL) (op 86), hl=0xC123, mem_rdata=0xFF -> M1: mem_rd @0xC123; M2: mem_wr @0xC123 with wdata=0xFE; done at the end of M2.
- BIT 2,(HL) (op 56), mem_rdata=0x00, f_in=0x00 -> 1 M-cycle read, f_out=0xA0, done; mem_wr never asserted.
- RLC B (op 00) -> done=err=1 on the clk after start; no strobes. A second start while busy during a RES (HL) is ignored.
- reset asserted during MEM_RD of SET 5,(HL) -> next clk: IDLE, busy=0, and no mem_wr or done ever issued.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared types and constants for the CB-prefix BIT/RES/SET sequencer.
// Field layout: op[7:6]=group, op[5:3]=bit index, op[2:0]=register.
package cb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXEC_R,
    MEM_RD,
    MEM_WR,
    ERR
  } state_e;

  localparam logic [1:0] GRP_ROT = 2'b00;
  localparam logic [1:0] GRP_BIT = 2'b01;
  localparam logic [1:0] GRP_RES = 2'b10;
  localparam logic [1:0] GRP_SET = 2'b11;

  localparam logic [2:0] R_HL_IND = 3'd6;

  localparam int FZ = 7;
  localparam int FN = 6;
  localparam int FH = 5;
  localparam int FC = 4;

  // BIT result: Z = inverted tested bit, N=0, H=1, C kept, low nibble zero.
  function automatic logic [7:0] bit_flags(input logic z, input logic c);
    logic [7:0] f;
    f     = 8'h00;
    f[FZ] = z;
    f[FN] = 1'b0;
    f[FH] = 1'b1;
    f[FC] = c;
    return f;
  endfunction

endpackage

// File: rtl/cb_bitop_seq_bitalu.sv
// Bit ALU datapath: tests, clears or sets bit b of operand a.
// Purely combinational; z is the inverted tested bit for every group.
module cb_bitop_seq_bitalu
  import cb_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [2:0] b_i,
  input  logic [1:0] grp_i,
  output logic [7:0] res_o,
  output logic       z_o
);

  logic [7:0] mask;

  always_comb begin
    mask  = 8'h01 << b_i;
    z_o   = ~a_i[b_i];
    res_o = a_i;
    case (grp_i)
      GRP_RES: res_o = a_i & ~mask;
      GRP_SET: res_o = a_i | mask;
      default: res_o = a_i;
    endcase
  end

endmodule

// File: rtl/cb_bitop_seq.sv
// Multi-cycle sequencer for CB-prefixed BIT/RES/SET, driving the bit ALU
// and writing back register, memory or flags on M-cycle boundaries.
module cb_bitop_seq
  import cb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mcyc_en,
  input  logic        start,
  input  logic [7:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  reg_sel,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  input  logic [15:0] hl,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  f_in,
  output logic        f_we,
  output logic [7:0]  f_out
);

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] hl_q, hl_d;
  logic [7:0]  tmp_q, tmp_d;

  logic [7:0]  alu_a;
  logic [7:0]  alu_res;
  logic        alu_z;
  logic [1:0]  grp;
  logic        unused_f;

  assign grp      = op_q[7:6];
  assign unused_f = ^{f_in[7:5], f_in[3:0]};

  cb_bitop_seq_bitalu u_alu (
    .a_i   (alu_a),
    .b_i   (op_q[5:3]),
    .grp_i (grp),
    .res_o (alu_res),
    .z_o   (alu_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 8'h00;
      hl_q    <= 16'h0000;
      tmp_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hl_q    <= hl_d;
      tmp_q   <= tmp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hl_d      = hl_q;
    tmp_d     = tmp_q;
    done      = 1'b0;
    err       = 1'b0;
    reg_we    = 1'b0;
    reg_wdata = 8'h00;
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    f_we      = 1'b0;
    f_out     = 8'h00;
    busy      = (state_q != IDLE);
    reg_sel   = op_q[2:0];

    // Read data is only valid at mcyc_en, so BIT (HL) tests it directly.
    case (state_q)
      MEM_RD:  alu_a = mem_rdata;
      MEM_WR:  alu_a = tmp_q;
      default: alu_a = reg_rdata;
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = opcode;
          hl_d = hl;
          if (opcode[7:6] == GRP_ROT)       state_d = ERR;
          else if (opcode[2:0] != R_HL_IND) state_d = EXEC_R;
          else                              state_d = MEM_RD;
        end
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      EXEC_R: begin
        if (mcyc_en) begin
          if (grp == GRP_BIT) begin
            f_we  = 1'b1;
            f_out = bit_flags(alu_z, f_in[FC]);
          end else begin
            reg_we    = 1'b1;
            reg_wdata = alu_res;
          end
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = hl_q;
        if (mcyc_en) begin
          tmp_d = mem_rdata;
          if (grp == GRP_BIT) begin
            f_we    = 1'b1;
            f_out   = bit_flags(alu_z, f_in[FC]);
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MEM_WR;
          end
        end
      end
      MEM_WR: begin
        mem_wr    = 1'b1;
        mem_addr  = hl_q;
        mem_wdata = alu_res;
        if (mcyc_en) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
